ddr_frame_reader: RTL and testbench

Parametrised Avalon-MM burst read master that fetches a video frame from DDR SDRAM one line at a time, on request from the display/processing pipeline. It is the next-generation frame-buffer reader on the `clk_100` SDRAM side. Frame geometry, burst length, pixel width and line stride are configurable. It adds pipelined multi-burst issue with an outstanding-burst limit, single-shot or continuous (looping) frame mode, and start/end-of-line/frame markers on the pixel stream.

---
 rtl/ddr_frame_reader.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ddr_frame_reader.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_reader.sv
// ddr_frame_reader: Avalon-MM burst read master that streams one frame
// line per request from SDRAM, with SOL/EOL/SOF/EOF pixel markers.
module ddr_frame_reader #(
  parameter int ADDR_W          = 30,
  parameter int DATA_W          = 32,
  parameter int PIX_W           = 24,
  parameter int BURST_LEN       = 80,
  parameter int BURSTS_PER_LINE = 16,
  parameter int LINES           = 720,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic              continuous,
  input  logic              line_request,
  output logic              frame_buffer_ready,
  output logic              busy,
  output logic              line_done,
  output logic              frame_done,
  output logic              req_overrun,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic              avm_read,
  output logic [ADDR_W-1:0] avm_address,
  output logic [7:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);
  localparam int LINE_BEATS = BURST_LEN * BURSTS_PER_LINE;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(BURSTS_PER_LINE + 1);
  localparam int LW = $clog2(LINES + 1);
  localparam int KW = $clog2(LINE_BEATS + 1);

  localparam logic [OW-1:0] MAX_O  = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] ONE_O  = OW'(1);
  localparam logic [BW-1:0] LAST_B = BW'(BURSTS_PER_LINE - 1);
  localparam logic [BW-1:0] ONE_B  = BW'(1);
  localparam logic [LW-1:0] LAST_L = LW'(LINES - 1);
  localparam logic [LW-1:0] ONE_L  = LW'(1);
  localparam logic [KW-1:0] LAST_K = KW'(LINE_BEATS - 1);
  localparam logic [KW-1:0] ONE_K  = KW'(1);
  localparam logic [7:0]    LAST_W = 8'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] B_STEP = ADDR_W'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ISSUE, S_DRAIN, S_END
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
  logic              cont_q, cont_d;
  logic [LW-1:0]     line_idx_q, line_idx_d;
  logic [BW-1:0]     burst_idx_q, burst_idx_d;
  logic [7:0]        wbeat_q, wbeat_d;
  logic [KW-1:0]     kbeat_q, kbeat_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic              fbr_q, fbr_d;
  logic              full_q, full_d;
  logic              ld_q, ld_d;
  logic              fd_q, fd_d;
  logic              pv_q, pv_d;
  logic [PIX_W-1:0]  pd_q, pd_d;
  logic              sol_q, sol_d;
  logic              eol_q, eol_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;

  logic              accept;
  logic              rd_ok;
  logic              burst_end;
  logic              consume;
  logic              last_k;
  logic [DATA_W-1:0] unused_rd;

  assign unused_rd = avm_readdata;

  assign avm_read = (state_q == S_ISSUE) && (outst_q < MAX_O);
  assign avm_address = burst_addr_q;
  assign avm_burstcount = 8'(BURST_LEN);

  assign accept = avm_read && !avm_waitrequest;
  // Beats with nothing outstanding belong to no burst of ours.
  assign rd_ok = avm_readdatavalid && (outst_q != '0);
  assign burst_end = rd_ok && (wbeat_q == LAST_W);
  assign consume = (state_q == S_WAIT) && pend_q;
  assign last_k = (kbeat_q == LAST_K);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    stride_d     = stride_q;
    cont_d       = cont_q;
    line_addr_d  = line_addr_q;
    burst_addr_d = burst_addr_q;
    line_idx_d   = line_idx_q;
    burst_idx_d  = burst_idx_q;
    wbeat_d      = wbeat_q;
    kbeat_d      = kbeat_q;
    outst_d      = outst_q;
    ovr_d        = ovr_q;
    fbr_d        = fbr_q || start;
    full_d       = full_q;
    ld_d         = 1'b0;
    fd_d         = 1'b0;
    pv_d         = rd_ok;
    pd_d         = pd_q;
    sol_d        = 1'b0;
    eol_d        = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;

    pend_d = 1'b0;
    if (state_q != S_IDLE) begin
      pend_d = (pend_q && !consume) || line_request;
      if (line_request && pend_q && !consume)
        ovr_d = 1'b1;
    end

    unique case ({accept, burst_end})
      2'b10:   outst_d = outst_q + ONE_O;
      2'b01:   outst_d = outst_q - ONE_O;
      default: outst_d = outst_q;
    endcase

    if (rd_ok) begin
      wbeat_d = burst_end ? 8'd0 : wbeat_q + 8'd1;
      kbeat_d = last_k ? '0 : kbeat_q + ONE_K;
      if (last_k)
        full_d = 1'b1;
      pd_d  = avm_readdata[PIX_W-1:0];
      sol_d = (kbeat_q == '0);
      eol_d = last_k;
      sof_d = (kbeat_q == '0) && (line_idx_q == '0);
      eof_d = last_k && (line_idx_q == LAST_L);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WAIT;
          base_d      = base_addr;
          stride_d    = line_stride;
          cont_d      = continuous;
          line_addr_d = base_addr;
          line_idx_d  = '0;
          ovr_d       = 1'b0;
        end
      end
      S_WAIT: begin
        if (pend_q) begin
          state_d      = S_ISSUE;
          burst_idx_d  = '0;
          burst_addr_d = line_addr_q;
          full_d       = 1'b0;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          burst_idx_d  = burst_idx_q + ONE_B;
          burst_addr_d = burst_addr_q + B_STEP;
          if (burst_idx_q == LAST_B)
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((outst_q == '0) && full_q)
          state_d = S_END;
      end
      S_END: begin
        ld_d = 1'b1;
        if (line_idx_q == LAST_L) begin
          fd_d        = 1'b1;
          line_idx_d  = '0;
          line_addr_d = base_q;
          state_d     = cont_q ? S_WAIT : S_IDLE;
        end else begin
          line_idx_d  = line_idx_q + ONE_L;
          line_addr_d = line_addr_q + stride_q;
          state_d     = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      stride_q     <= '0;
      cont_q       <= 1'b0;
      line_addr_q  <= '0;
      burst_addr_q <= '0;
      line_idx_q   <= '0;
      burst_idx_q  <= '0;
      wbeat_q      <= '0;
      kbeat_q      <= '0;
      outst_q      <= '0;
      pend_q       <= 1'b0;
      ovr_q        <= 1'b0;
      fbr_q        <= 1'b0;
      full_q       <= 1'b0;
      ld_q         <= 1'b0;
      fd_q         <= 1'b0;
      pv_q         <= 1'b0;
      pd_q         <= '0;
      sol_q        <= 1'b0;
      eol_q        <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      stride_q     <= stride_d;
      cont_q       <= cont_d;
      line_addr_q  <= line_addr_d;
      burst_addr_q <= burst_addr_d;
      line_idx_q   <= line_idx_d;
      burst_idx_q  <= burst_idx_d;
      wbeat_q      <= wbeat_d;
      kbeat_q      <= kbeat_d;
      outst_q      <= outst_d;
      pend_q       <= pend_d;
      ovr_q        <= ovr_d;
      fbr_q        <= fbr_d;
      full_q       <= full_d;
      ld_q         <= ld_d;
      fd_q         <= fd_d;
      pv_q         <= pv_d;
      pd_q         <= pd_d;
      sol_q        <= sol_d;
      eol_q        <= eol_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
    end
  end

  assign frame_buffer_ready = fbr_q;
  assign busy        = (state_q != S_IDLE);
  assign line_done   = ld_q;
  assign frame_done  = fd_q;
  assign req_overrun = ovr_q;
  assign pix_valid   = pv_q;
  assign pix_data    = pd_q;
  assign pix_sol     = sol_q;
  assign pix_eol     = eol_q;
  assign pix_sof     = sof_q;
  assign pix_eof     = eof_q;
endmodule

// File: tb/tb_ddr_frame_reader.sv
// tb_ddr_frame_reader: randomized bench with an Avalon memory model and
// a queue-based reference of expected bursts and marked pixels.
module tb_ddr_frame_reader;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int PW = 24;
  localparam int BL = 4;
  localparam int BPL = 2;
  localparam int NL = 3;
  localparam int LB = BL * BPL;

  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          start2 = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] line_stride = '0;
  logic          continuous = 1'b0;
  logic          line_request = 1'b0;
  logic          line_request2 = 1'b0;

  logic          frame_buffer_ready, busy, line_done, frame_done;
  logic          req_overrun, pix_valid;
  logic          pix_sol, pix_eol, pix_sof, pix_eof;
  logic [PW-1:0] pix_data;
  logic          avm_read;
  logic [AW-1:0] avm_address;
  logic [7:0]    avm_burstcount;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;

  logic          fbr2, busy2, ld2, fd2, ovr2, pv2;
  logic          sol2, eol2, sof2, eof2;
  logic [PW-1:0] pd2;
  logic          rd2;
  logic [AW-1:0] addr2;
  logic [7:0]    bc2;
  logic          wr2 = 1'b0;
  logic [DW-1:0] rdata2 = '0;
  logic          rdv2 = 1'b0;

  ddr_frame_reader #(
    .ADDR_W(AW), .DATA_W(DW), .PIX_W(PW), .BURST_LEN(BL),
    .BURSTS_PER_LINE(BPL), .LINES(NL), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_100(clk_100), .reset(reset), .start(start),
    .base_addr(base_addr), .line_stride(line_stride),
    .continuous(continuous), .line_request(line_request),
    .frame_buffer_ready(frame_buffer_ready), .busy(busy),
    .line_done(line_done), .frame_done(frame_done),
    .req_overrun(req_overrun), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_sol(pix_sol), .pix_eol(pix_eol),
    .pix_sof(pix_sof), .pix_eof(pix_eof), .avm_read(avm_read),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  ddr_frame_reader #(
    .ADDR_W(AW), .DATA_W(DW), .PIX_W(PW), .BURST_LEN(BL),
    .BURSTS_PER_LINE(BPL), .LINES(NL), .MAX_OUTSTANDING(1)
  ) dut_mo1 (
    .clk_100(clk_100), .reset(reset), .start(start2),
    .base_addr(base_addr), .line_stride(line_stride),
    .continuous(continuous), .line_request(line_request2),
    .frame_buffer_ready(fbr2), .busy(busy2),
    .line_done(ld2), .frame_done(fd2),
    .req_overrun(ovr2), .pix_data(pd2),
    .pix_valid(pv2), .pix_sol(sol2), .pix_eol(eol2),
    .pix_sof(sof2), .pix_eof(eof2), .avm_read(rd2),
    .avm_address(addr2), .avm_burstcount(bc2),
    .avm_waitrequest(wr2), .avm_readdata(rdata2),
    .avm_readdatavalid(rdv2)
  );

  int passed = 0;
  int failed = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  bit rnd_mode = 1'b0;
  int lat = 2;
  bit hold_arm = 1'b0;
  bit hold_done = 1'b0;
  int hold_left = 0;
  int hold_n = 0;
  int acc_cnt = 0;
  int pixcnt = 0;
  int ldcnt = 0;
  int fdcnt = 0;
  bit no_pix = 1'b0;
  logic [AW-1:0] bq_a[$];
  int            bq_t[$];
  logic [AW-1:0] eb[$];
  logic [27:0]   ep[$];

  int acc2 = 0;
  int pix2cnt = 0;
  int ld2cnt = 0;
  logic [AW-1:0] q2a[$];
  int            q2t[$];
  logic [25:0]   ep2[$];

  int ref_line = 0;
  logic [AW-1:0] ref_addr = '0;
  logic [AW-1:0] ref_base = '0;
  logic [AW-1:0] ref_stride = '0;

  task automatic mem1();
    logic [95:0] e;
    if (hold_arm && !hold_done && avm_read) begin
      hold_left = 5;
      hold_done = 1'b1;
    end
    if (hold_left > 0) begin
      chk("hold_stable", {avm_read, avm_address}, {1'b1, 30'h100});
      hold_n++;
      hold_left--;
      avm_waitrequest = 1'b1;
    end else begin
      avm_waitrequest = rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    if (avm_read && !avm_waitrequest) begin
      acc_cnt++;
      e = (eb.size() > 0) ? 96'(eb.pop_front()) : {96{1'bx}};
      chk("burst_addr", 96'(avm_address), e);
      for (int i = 0; i < BL; i++) begin
        bq_a.push_back(avm_address + AW'(i));
        bq_t.push_back(cyc + lat + (rnd_mode ? $urandom_range(0, 3) : 0));
      end
    end
    if (bq_a.size() > 0 && bq_t[0] <= cyc &&
        (!rnd_mode || $urandom_range(0, 3) != 0)) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = DW'(bq_a.pop_front());
      void'(bq_t.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
    end
  endtask

  task automatic mem2();
    logic [95:0] e;
    if (rd2) begin
      chk("mo1_serial", 96'(q2a.size()), 96'd0);
      acc2++;
      for (int i = 0; i < BL; i++) begin
        q2a.push_back(addr2 + AW'(i));
        q2t.push_back(cyc + 10);
      end
    end
    if (q2a.size() > 0 && q2t[0] <= cyc) begin
      rdv2 = 1'b1;
      rdata2 = DW'(q2a.pop_front());
      void'(q2t.pop_front());
    end else begin
      rdv2 = 1'b0;
      rdata2 = $urandom;
    end
    if (pv2) begin
      pix2cnt++;
      e = (ep2.size() > 0) ? 96'(ep2.pop_front()) : {96{1'bx}};
      chk("mo1_pix", {pd2, sol2, eol2}, e);
    end
    if (ld2) ld2cnt++;
  endtask

  task automatic mon();
    logic [95:0] e;
    if (pix_valid) begin
      pixcnt++;
      if (no_pix) begin
        chk("stray_pix", 96'(pix_valid), 96'd0);
      end else begin
        e = (ep.size() > 0) ? 96'(ep.pop_front()) : {96{1'bx}};
        chk("pix", {pix_data, pix_sol, pix_eol, pix_sof, pix_eof}, e);
      end
    end
    if (line_done) ldcnt++;
    if (frame_done) begin
      fdcnt++;
      chk("fd_with_ld", 96'(line_done), 96'd1);
    end
  endtask

  task automatic tick();
    @(negedge clk_100);
    cyc++;
    mon();
    mem1();
    mem2();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_line();
    logic [AW-1:0] a;
    for (int w = 0; w < LB; w++) begin
      a = ref_addr + AW'(w);
      if (w % BL == 0) eb.push_back(a);
      ep.push_back({a[PW-1:0], w == 0, w == LB - 1,
                    w == 0 && ref_line == 0,
                    w == LB - 1 && ref_line == NL - 1});
    end
    ref_line++;
    if (ref_line == NL) begin
      ref_line = 0;
      ref_addr = ref_base;
    end else begin
      ref_addr = ref_addr + ref_stride;
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] s,
                          input logic c);
    base_addr = b;
    line_stride = s;
    continuous = c;
    ref_base = b;
    ref_stride = s;
    ref_addr = b;
    ref_line = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic request();
    expect_line();
    line_request = 1'b1;
    tick();
    line_request = 1'b0;
  endtask

  task automatic wait_ld(input int target);
    int n = 0;
    while (ldcnt < target && n < 400) begin
      tick();
      n++;
    end
    chk("line_done_wait", 96'(ldcnt >= target), 96'd1);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 200) begin
      tick();
      n++;
    end
    chk("accept_wait", 96'(acc_cnt >= target), 96'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    tick();
  endtask

  function automatic logic [95:0] outs1();
    return {frame_buffer_ready, busy, line_done, frame_done, req_overrun,
            pix_data, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof,
            avm_read, avm_address};
  endfunction

  initial begin
    int n;
    int b_acc, b_fd, b_pix, b_ld;
    ticks(3);
    chk("reset_outs", outs1(), 96'd0);
    chk("reset_bc", 96'(avm_burstcount), 96'd4);
    chk("reset_outs_mo1",
        {fbr2, busy2, ld2, fd2, ovr2, pd2, pv2, sol2, eol2, sof2, eof2,
         rd2, addr2}, 96'd0);
    chk("reset_bc_mo1", 96'(bc2), 96'd4);
    reset = 1'b0;
    tick();

    // One outstanding burst at a time, 10-cycle memory latency.
    base_addr = 30'h200;
    line_stride = 30'h40;
    continuous = 1'b0;
    for (int w = 0; w < LB; w++)
      ep2.push_back({24'h200 + 24'(w), w == 0, w == LB - 1});
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    line_request2 = 1'b1;
    tick();
    line_request2 = 1'b0;
    n = 0;
    while (ld2cnt < 1 && n < 200) begin
      tick();
      n++;
    end
    chk("mo1_line_done", 96'(ld2cnt), 96'd1);
    chk("mo1_bursts", 96'(acc2), 96'd2);
    chk("mo1_pix_count", 96'(pix2cnt), 96'd8);

    // Single frame with random waitrequest and data gaps.
    rnd_mode = 1'b1;
    lat = 2;
    do_start(30'h100, 30'h40, 1'b0);
    chk("fbr_set", 96'(frame_buffer_ready), 96'd1);
    chk("busy_armed", 96'(busy), 96'd1);
    for (int l = 0; l < NL; l++) begin
      request();
      wait_ld(l + 1);
    end
    ticks(5);
    chk("single_busy_off", 96'(busy), 96'd0);
    chk("single_lines", 96'(ldcnt), 96'd3);
    chk("single_frames", 96'(fdcnt), 96'd1);
    chk("single_pixels", 96'(pixcnt), 96'd24);
    chk("single_no_overrun", 96'(req_overrun), 96'd0);
    chk("single_bursts_left", 96'(eb.size()), 96'd0);

    // First burst held off by waitrequest for five cycles.
    do_reset();
    chk("fbr_cleared", 96'(frame_buffer_ready), 96'd0);
    rnd_mode = 1'b0;
    hold_arm = 1'b1;
    b_acc = acc_cnt;
    b_ld = ldcnt;
    do_start(30'h100, 30'h40, 1'b0);
    request();
    wait_ld(b_ld + 1);
    chk("hold_cycles", 96'(hold_n), 96'd5);
    chk("hold_accepts", 96'(acc_cnt - b_acc), 96'd2);

    // Continuous mode wraps to line 0 after the last line.
    do_reset();
    rnd_mode = 1'b1;
    b_fd = fdcnt;
    b_ld = ldcnt;
    do_start(30'h100, 30'h40, 1'b1);
    for (int l = 0; l < 4; l++) begin
      request();
      wait_ld(b_ld + l + 1);
    end
    ticks(3);
    chk("cont_frames", 96'(fdcnt - b_fd), 96'd1);
    chk("cont_busy", 96'(busy), 96'd1);
    chk("cont_pix_left", 96'(ep.size()), 96'd0);

    // Requests pile up while the current line drains.
    rnd_mode = 1'b0;
    lat = 8;
    b_acc = acc_cnt;
    b_ld = ldcnt;
    request();
    expect_line();
    wait_acc(b_acc + 2);
    line_request = 1'b1;
    tick();
    line_request = 1'b0;
    tick();
    line_request = 1'b1;
    tick();
    line_request = 1'b0;
    chk("overrun_set", 96'(req_overrun), 96'd1);
    tick();
    line_request = 1'b1;
    tick();
    line_request = 1'b0;
    wait_ld(b_ld + 1);
    tick();
    chk("restart_immediate", {avm_read, avm_address}, {1'b1, 30'h180});
    wait_ld(b_ld + 2);
    ticks(2);
    chk("overrun_sticky", 96'(req_overrun), 96'd1);
    chk("drain_pix_left", 96'(ep.size()), 96'd0);

    // Reset with two bursts in flight; late beats must be dropped.
    lat = 10;
    b_acc = acc_cnt;
    eb.push_back(30'h100);
    eb.push_back(30'h104);
    line_request = 1'b1;
    tick();
    line_request = 1'b0;
    wait_acc(b_acc + 2);
    tick();
    no_pix = 1'b1;
    b_pix = pixcnt;
    reset = 1'b1;
    tick();
    chk("rst_read_off", 96'(avm_read), 96'd0);
    chk("rst_outs", outs1(), 96'd0);
    reset = 1'b0;
    ticks(25);
    chk("rst_no_pix", 96'(pixcnt - b_pix), 96'd0);
    chk("rst_outs_after", outs1(), 96'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
